// File: rtl/hwpe_stream_tcdm_responder.sv
// hwpe_stream_tcdm_responder
//
// Multi-channel TCDM target backed by a single-port DEPTH x 32-bit memory.
// One channel is served per cycle, chosen round-robin. A served request
// completes one cycle later with an r_valid pulse on the same channel. Reads
// return the word; writes return zero data.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset (control state only)
//   clear_i         synchronous soft clear of control state; blocks grants
//   in_req_i        per-channel request
//   in_add_i        per-channel byte address, 32 bits each (channel c at [32c+:32])
//   in_wen_i        per-channel write-enable, active low (1 = read)
//   in_be_i         per-channel byte enables, 4 bits each
//   in_data_i       per-channel write data, 32 bits each
//   in_gnt_o        per-channel grant (combinational, at most one hot)
//   in_r_data_o     per-channel response data, 32 bits each
//   in_r_valid_o    per-channel response valid
//   conflict_cnt_o  saturating count of cycles with >= 2 requests
module hwpe_stream_tcdm_responder #(
    parameter int NB_CHAN = 2,
    parameter int DEPTH   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [NB_CHAN-1:0]     in_req_i,
    input  logic [NB_CHAN*32-1:0]  in_add_i,
    input  logic [NB_CHAN-1:0]     in_wen_i,
    input  logic [NB_CHAN*4-1:0]   in_be_i,
    input  logic [NB_CHAN*32-1:0]  in_data_i,
    output logic [NB_CHAN-1:0]     in_gnt_o,
    output logic [NB_CHAN*32-1:0]  in_r_data_o,
    output logic [NB_CHAN-1:0]     in_r_valid_o,
    output logic [31:0]            conflict_cnt_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CH_W = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     rdata_q;

    logic [CH_W-1:0] rr_q;
    logic            vld_q;
    logic [CH_W-1:0] resp_ch_q;
    logic            resp_rd_q;
    logic [31:0]     cnt_q;

    logic            win_vld;
    logic [CH_W-1:0] win_idx;
    logic [CH_W-1:0] cand_idx;
    logic            grant_vld;
    logic [31:0]     sel_add;
    logic            sel_wen;
    logic [3:0]      sel_be;
    logic [31:0]     sel_data;
    logic [AW-1:0]   sel_widx;
    logic [CH_W-1:0] rr_next;
    int              n_req;
    logic            conflict;
    logic            unused_addr_bits;

    // Round-robin search starting at rr_q; first requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int i = 0; i < NB_CHAN; i++) begin
            cand_idx = CH_W'((int'(rr_q) + i) % NB_CHAN);
            if (!win_vld && in_req_i[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // A clear cycle issues no grant, so nothing is written or answered.
    assign grant_vld = win_vld & ~clear_i;

    always_comb begin
        in_gnt_o = '0;
        sel_add  = '0;
        sel_wen  = 1'b1;
        sel_be   = '0;
        sel_data = '0;
        n_req    = 0;
        for (int c = 0; c < NB_CHAN; c++) begin
            in_gnt_o[c] = grant_vld && (win_idx == CH_W'(c));
            if (win_idx == CH_W'(c)) begin
                sel_add  = in_add_i[c*32 +: 32];
                sel_wen  = in_wen_i[c];
                sel_be   = in_be_i[c*4 +: 4];
                sel_data = in_data_i[c*32 +: 32];
            end
            n_req = n_req + int'(in_req_i[c]);
        end
    end

    // Word index only; byte offset and bits above the memory size alias.
    assign sel_widx         = sel_add[AW+1:2];
    assign unused_addr_bits = ^{sel_add[31:AW+2], sel_add[1:0]};
    assign conflict         = (n_req >= 2);
    assign rr_next          = (win_idx == CH_W'(NB_CHAN - 1)) ? '0 : win_idx + 1'b1;

    // Memory and read register: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (grant_vld) begin
            if (!sel_wen) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel_be[k]) begin
                        mem_q[sel_widx][8*k +: 8] <= sel_data[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[sel_widx];
            end
        end
    end

    // Arbitration pointer, pending response and conflict counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            vld_q     <= 1'b0;
            resp_ch_q <= '0;
            resp_rd_q <= 1'b0;
            cnt_q     <= '0;
        end else if (clear_i) begin
            rr_q      <= '0;
            vld_q     <= 1'b0;
            resp_rd_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vld_q     <= win_vld;
            resp_ch_q <= win_idx;
            resp_rd_q <= sel_wen;
            if (win_vld) begin
                rr_q <= rr_next;
            end
            if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // A clear arriving in the response cycle suppresses the response.
    always_comb begin
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int c = 0; c < NB_CHAN; c++) begin
            in_r_valid_o[c] = vld_q && !clear_i && (resp_ch_q == CH_W'(c));
            if (in_r_valid_o[c] && resp_rd_q) begin
                in_r_data_o[c*32 +: 32] = rdata_q;
            end
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/hwpe_stream_tcdm_responder.md
HWPE_STREAM_TCDM_RESPONDER -- requirements
Module: hwpe_stream_tcdm_responder

Interface
REQ-001 SHALL have parameter NB_CHAN, default 2, number of TCDM slave channels (>=1).
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words in the internal memory (power of two).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous soft clear of control state.
REQ-006 SHALL have port in  slave hwpe_stream_intf_tcdm array [NB_CHAN-1:0]  TCDM targets (req, add[31:0], wen, be[3:0], data[31:0] in; gnt, r_data[31:0], r_valid out).
REQ-007 SHALL have port conflict_cnt_o  output  32  count of cycles with two or more channels requesting simultaneously.

Function
REQ-008 SHALL hold a single-port array of DEPTH x 32-bit words; word index = add[$clog2(DEPTH)+1:2]; add[1:0] and upper bits ignored (aliasing modulo DEPTH).
REQ-009 SHALL grant at most one channel per cycle; gnt is combinational from req and the round-robin pointer rr_q.
REQ-010 SHALL select as winner the first channel with req=1 searching rr_q, rr_q+1, ... cyclically modulo NB_CHAN; only the winner sees gnt=1.
REQ-011 SHALL update rr_q to (winner+1) mod NB_CHAN on a granted cycle; rr_q unchanged when no req.
REQ-012 SHALL treat wen=0 as write: on the grant edge, byte k of word written with data[8k+7:8k] where be[k]=1; be=4'b0000 leaves memory unchanged.
REQ-013 SHALL treat wen=1 as read: r_data of the winning channel = word contents at the grant cycle, presented in the next cycle.
REQ-014 SHALL assert r_valid on exactly the channel granted in the previous cycle, for one cycle, for both reads and writes; all other channels r_valid=0.
REQ-015 SHALL drive r_data=32'h0 on every channel whose r_valid=0 and on a channel completing a write.
REQ-016 SHALL give a read granted in cycle t+1 to an address written in cycle t the newly written data (write-first across cycles).
REQ-017 SHALL increment conflict_cnt_o by 1 each cycle where popcount(req)>=2, saturating at 32'hFFFF_FFFF.
REQ-018 SHALL, with NB_CHAN=1, grant whenever req=1 (rr_q constant 0), and conflict_cnt_o remains 0.
REQ-019 SHALL not depend on initiator holding req until gnt; a dropped ungranted req is simply not served.

Reset
REQ-020 SHALL on rst_ni=0 set rr_q=0, all r_valid=0, all r_data=0, conflict_cnt_o=0; gnt follows REQ-010 with rr_q=0.
REQ-021 SHALL not reset memory contents; reads of never-written words are undefined.
REQ-022 SHALL on clear_i=1 set rr_q=0, pending response=none, conflict_cnt_o=0 at the next edge; no grant is issued and memory is not written in a cycle with clear_i=1.
REQ-023 SHALL, on reset or clear asserted the cycle after a grant, suppress that grant's r_valid.

Verification
REQ-024 Single write/read: ch0 write add=0x10, data=0xDEADBEEF, be=F; next ch0 read add=0x10 -> gnt same cycle each, r_valid 1 cycle later, r_data=0xDEADBEEF.
REQ-025 Byte enables: write 0x11223344 be=F, then 0xAABBCCDD be=4'b0101 same address, read -> r_data=0x11BB33DD.
REQ-026 Contention: NB_CHAN=4, all req held high 8 cycles from reset -> gnt order ch0,1,2,3,0,1,2,3; conflict_cnt_o=8 afterwards.
REQ-027 Back-to-back RAW: ch1 write 0x55 to add 0x40 in cycle t, ch0 read add 0x40 in cycle t+1 -> ch0 r_valid at t+2 with 0x55; ch1 r_valid at t+1 with r_data=0.
REQ-028 Clear mid-traffic: grant ch2 read in cycle t, clear_i=1 in cycle t+1 -> no r_valid at t+1 or t+2, conflict_cnt_o=0, next grant searches from ch0.
REQ-029 Aliasing: DEPTH=1024, write add=0x0000_1004 value 0x1, read add=0x4 -> r_data=0x1.
